// File: rtl/aes_job_scheduler.sv
// Shares one AES decryption core between two requesters using round-robin arbitration.
// Latches each job, drives the core handshake, guards it with a watchdog and returns the plaintext.
module aes_job_scheduler #(
  parameter int KEY_SETTLE     = 2,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         req0_valid,
  input  logic [127:0] req0_key,
  input  logic [127:0] req0_msg,
  output logic         req0_ready,
  output logic         rsp0_valid,
  output logic [127:0] rsp0_data,
  output logic         rsp0_err,
  input  logic         rsp0_ack,
  input  logic         req1_valid,
  input  logic [127:0] req1_key,
  input  logic [127:0] req1_msg,
  output logic         req1_ready,
  output logic         rsp1_valid,
  output logic [127:0] rsp1_data,
  output logic         rsp1_err,
  input  logic         rsp1_ack,
  output logic         AES_START,
  input  logic         AES_DONE,
  output logic [127:0] AES_KEY,
  output logic [127:0] AES_MSG_ENC,
  input  logic [127:0] AES_MSG_DEC,
  output logic         core_rst
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SC_W = (KEY_SETTLE > 1) ? $clog2(KEY_SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RUN     = 3'd2,
    S_RELEASE = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic [127:0]      key_q, key_d;
  logic [127:0]      msg_q, msg_d;
  logic [127:0]      result_q, result_d;
  logic              err_q, err_d;
  logic [SC_W-1:0]   settle_q, settle_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              start_q, start_d;
  logic              core_rst_q, core_rst_d;
  logic              rsp0_valid_q, rsp0_valid_d;
  logic [127:0]      rsp0_data_q, rsp0_data_d;
  logic              rsp0_err_q, rsp0_err_d;
  logic              rsp1_valid_q, rsp1_valid_d;
  logic [127:0]      rsp1_data_q, rsp1_data_d;
  logic              rsp1_err_q, rsp1_err_d;
  logic              grant_any;
  logic              grant_port;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    grant_any  = 1'b0;
    grant_port = 1'b0;
    if ((state_q == S_IDLE) && !rsp0_valid_q && !rsp1_valid_q) begin
      if (req0_valid && req1_valid) begin
        grant_any  = 1'b1;
        grant_port = ~last_grant_q;
      end else if (req0_valid) begin
        grant_any  = 1'b1;
        grant_port = 1'b0;
      end else if (req1_valid) begin
        grant_any  = 1'b1;
        grant_port = 1'b1;
      end else begin
        grant_any  = 1'b0;
        grant_port = 1'b0;
      end
    end else begin
      grant_any  = 1'b0;
      grant_port = 1'b0;
    end
  end

  assign req0_ready = grant_any & ~grant_port;
  assign req1_ready = grant_any & grant_port;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    key_d        = key_q;
    msg_d        = msg_q;
    result_d     = result_q;
    err_d        = err_q;
    settle_d     = settle_q;
    wd_d         = wd_q;
    start_d      = start_q;
    core_rst_d   = 1'b0;
    rsp0_valid_d = rsp0_valid_q;
    rsp0_data_d  = rsp0_data_q;
    rsp0_err_d   = rsp0_err_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp1_data_d  = rsp1_data_q;
    rsp1_err_d   = rsp1_err_q;
    case (state_q)
      S_IDLE: begin
        if (grant_any) begin
          key_d    = grant_port ? req1_key : req0_key;
          msg_d    = grant_port ? req1_msg : req0_msg;
          owner_d  = grant_port;
          settle_d = '0;
          wd_d     = '0;
          state_d  = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (settle_q == SC_W'(KEY_SETTLE - 1)) begin
          start_d = 1'b1;
          wd_d    = '0;
          state_d = S_RUN;
        end else begin
          settle_d = settle_q + SC_W'(1);
        end
      end
      S_RUN: begin
        wd_d = wd_q + WD_W'(1);
        // AES_DONE takes priority over a coincident timeout.
        if (AES_DONE) begin
          result_d = AES_MSG_DEC;
          err_d    = 1'b0;
          start_d  = 1'b0;
          state_d  = S_RELEASE;
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          result_d   = '0;
          err_d      = 1'b1;
          start_d    = 1'b0;
          core_rst_d = 1'b1;
          state_d    = S_RELEASE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RELEASE: begin
        if (!AES_DONE) begin
          state_d = S_RESP;
          if (owner_q) begin
            rsp1_valid_d = 1'b1;
            rsp1_data_d  = result_q;
            rsp1_err_d   = err_q;
          end else begin
            rsp0_valid_d = 1'b1;
            rsp0_data_d  = result_q;
            rsp0_err_d   = err_q;
          end
        end else begin
          state_d = S_RELEASE;
        end
      end
      S_RESP: begin
        if (owner_q ? rsp1_ack : rsp0_ack) begin
          rsp0_valid_d = 1'b0;
          rsp0_data_d  = '0;
          rsp0_err_d   = 1'b0;
          rsp1_valid_d = 1'b0;
          rsp1_data_d  = '0;
          rsp1_err_d   = 1'b0;
          last_grant_d = owner_q;
          state_d      = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // A reset mid-job drops the job without any response.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      key_q        <= '0;
      msg_q        <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
      settle_q     <= '0;
      wd_q         <= '0;
      start_q      <= 1'b0;
      core_rst_q   <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp0_err_q   <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp1_data_q  <= '0;
      rsp1_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      key_q        <= key_d;
      msg_q        <= msg_d;
      result_q     <= result_d;
      err_q        <= err_d;
      settle_q     <= settle_d;
      wd_q         <= wd_d;
      start_q      <= start_d;
      core_rst_q   <= core_rst_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp0_err_q   <= rsp0_err_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_data_q  <= rsp1_data_d;
      rsp1_err_q   <= rsp1_err_d;
    end
  end

  assign AES_START   = start_q;
  assign AES_KEY     = key_q;
  assign AES_MSG_ENC = msg_q;
  assign core_rst    = core_rst_q;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp0_data   = rsp0_data_q;
  assign rsp0_err    = rsp0_err_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp1_data   = rsp1_data_q;
  assign rsp1_err    = rsp1_err_q;

endmodule
